// File: rtl/clk_gen.sv
// Divided clock generator: produces a registered square wave of CLOCK_PERIOD ref_clk cycles,
// with single-cycle rise/fall strobes and a count of completed output periods.
module clk_gen #(
   parameter int unsigned CLOCK_PERIOD = 10,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             ref_clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             clk,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] cycles
);

   // Guard keeps widths legal so the elaboration error below is the one reported.
   localparam int unsigned PW   = (CLOCK_PERIOD < 2) ? 1 : $clog2(CLOCK_PERIOD);
   localparam int unsigned HIGH = CLOCK_PERIOD / 2;
   localparam int unsigned LOW  = CLOCK_PERIOD - HIGH;

   localparam logic [PW-1:0] LastPhase = PW'(CLOCK_PERIOD - 1);
   localparam logic [PW-1:0] RisePhase = PW'(LOW);

   if (CLOCK_PERIOD < 2) begin : g_bad_period
      $error("clk_gen: CLOCK_PERIOD must be >= 2");
   end

   logic [PW-1:0]    p_q, p_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;

   always_comb begin
      p_d      = p_q;
      clk_d    = clk_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      cycles_d = cycles_q;
      if (en) begin
         p_d    = (p_q == LastPhase) ? '0 : p_q + PW'(1);
         // Low phase first, so odd periods spend the extra cycle low.
         clk_d  = (p_d >= RisePhase);
         rise_d = (p_d == RisePhase);
         fall_d = (p_d == '0);
         if (p_d == RisePhase) begin
            cycles_d = cycles_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q      <= '0;
         clk_q    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         cycles_q <= '0;
      end else begin
         p_q      <= p_d;
         clk_q    <= clk_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cycles_q <= cycles_d;
      end
   end

   assign clk    = clk_q;
   assign rise   = rise_q;
   assign fall   = fall_q;
   assign cycles = cycles_q;

endmodule

// File: tb/tb_clk_gen.sv
// Directed bench for clk_gen: four instances (periods 10, 3, 2, and 4 with a 2-bit counter)
// share reset and enable; each task checks one of them against hand-derived waveforms.
module tb_clk_gen;

   logic ref_clk = 1'b0;
   logic rst_n   = 1'b0;
   logic en      = 1'b0;

   logic        clk10, rise10, fall10;
   logic [31:0] cyc10;
   logic        clk3, rise3, fall3;
   logic [31:0] cyc3;
   logic        clk2, rise2, fall2;
   logic [31:0] cyc2;
   logic        clk4, rise4, fall4;
   logic [1:0]  cyc4;

   int checks = 0;
   int errors = 0;

   always #5 ref_clk = ~ref_clk;

   clk_gen #(.CLOCK_PERIOD(10), .CNT_W(32)) u_p10 (
      .ref_clk(ref_clk), .rst_n(rst_n), .en(en),
      .clk(clk10), .rise(rise10), .fall(fall10), .cycles(cyc10)
   );
   clk_gen #(.CLOCK_PERIOD(3), .CNT_W(32)) u_p3 (
      .ref_clk(ref_clk), .rst_n(rst_n), .en(en),
      .clk(clk3), .rise(rise3), .fall(fall3), .cycles(cyc3)
   );
   clk_gen #(.CLOCK_PERIOD(2), .CNT_W(32)) u_p2 (
      .ref_clk(ref_clk), .rst_n(rst_n), .en(en),
      .clk(clk2), .rise(rise2), .fall(fall2), .cycles(cyc2)
   );
   clk_gen #(.CLOCK_PERIOD(4), .CNT_W(2)) u_p4 (
      .ref_clk(ref_clk), .rst_n(rst_n), .en(en),
      .clk(clk4), .rise(rise4), .fall(fall4), .cycles(cyc4)
   );

   // Sample just after the active edge.
   task automatic tick();
      @(posedge ref_clk);
      #1;
   endtask

   // Hold reset across two edges, release on a falling edge so the next rising edge is edge 1.
   task automatic do_reset();
      @(negedge ref_clk);
      rst_n = 1'b0;
      en    = 1'b1;
      @(negedge ref_clk);
      @(negedge ref_clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge ref_clk);
      rst_n = 1'b0;
      en    = 1'b1;
      tick();
      checks++;
      if ({clk10, rise10, fall10} !== 3'b000 || cyc10 !== 32'd0) begin
         errors++;
         $display("FAIL reset_p10: clk/rise/fall=%b%b%b cycles=%0d, want 000 cycles=0",
                  clk10, rise10, fall10, cyc10);
      end
      checks++;
      if ({clk3, clk2, clk4} !== 3'b000 || cyc3 !== 32'd0 || cyc2 !== 32'd0 || cyc4 !== 2'd0)
      begin
         errors++;
         $display("FAIL reset_others: clk3/2/4=%b%b%b cycles=%0d/%0d/%0d, want 000 0/0/0",
                  clk3, clk2, clk4, cyc3, cyc2, cyc4);
      end
   endtask

   task automatic test_period10();
      logic [1:15] clk_v;
      logic [1:15] rise_v;
      logic [1:15] fall_v;
      int          cyc_v [1:15];
      clk_v  = 15'b000011111000001;
      rise_v = 15'b000010000000001;
      fall_v = 15'b000000000100000;
      cyc_v  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
      do_reset();
      for (int e = 1; e <= 15; e++) begin
         tick();
         checks++;
         if (clk10 !== clk_v[e] || rise10 !== rise_v[e] || fall10 !== fall_v[e] ||
             cyc10 !== 32'(cyc_v[e])) begin
            errors++;
            $display("FAIL p10_edge%0d: clk/rise/fall=%b%b%b cycles=%0d, want %b%b%b cycles=%0d",
                     e, clk10, rise10, fall10, cyc10, clk_v[e], rise_v[e], fall_v[e], cyc_v[e]);
         end
      end
   endtask

   task automatic test_period3();
      logic [1:6] clk_v;
      logic [1:6] fall_v;
      clk_v  = 6'b010010;
      fall_v = 6'b001001;
      do_reset();
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if (clk3 !== clk_v[e] || rise3 !== clk_v[e] || fall3 !== fall_v[e]) begin
            errors++;
            $display("FAIL p3_edge%0d: clk/rise/fall=%b%b%b, want %b%b%b",
                     e, clk3, rise3, fall3, clk_v[e], clk_v[e], fall_v[e]);
         end
      end
      for (int e = 7; e <= 100; e++) tick();
      checks++;
      if (cyc3 !== 32'd33) begin
         errors++;
         $display("FAIL p3_cycles100: cycles=%0d, want 33", cyc3);
      end
   endtask

   task automatic test_period2();
      int want_cyc;
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         tick();
         want_cyc = (e + 1) / 2;
         checks++;
         if (clk2 !== e[0] || rise2 !== e[0] || fall2 !== ~e[0] ||
             cyc2 !== 32'(want_cyc)) begin
            errors++;
            $display("FAIL p2_edge%0d: clk/rise/fall=%b%b%b cycles=%0d, want %b%b%b cycles=%0d",
                     e, clk2, rise2, fall2, cyc2, e[0], e[0], ~e[0], want_cyc);
         end
      end
   endtask

   task automatic test_enable_hold();
      do_reset();
      for (int e = 1; e <= 7; e++) tick();
      @(negedge ref_clk);
      en = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         checks++;
         if (clk10 !== 1'b1 || rise10 !== 1'b0 || fall10 !== 1'b0 || cyc10 !== 32'd1) begin
            errors++;
            $display("FAIL hold_edge%0d: clk/rise/fall=%b%b%b cycles=%0d, want 100 cycles=1",
                     e, clk10, rise10, fall10, cyc10);
         end
      end
      @(negedge ref_clk);
      en = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         tick();
         checks++;
         if (clk10 !== (e < 3) || fall10 !== (e == 3) || rise10 !== 1'b0) begin
            errors++;
            $display("FAIL resume_edge%0d: clk/rise/fall=%b%b%b, want %b0%b",
                     e, clk10, rise10, fall10, (e < 3), (e == 3));
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int e = 1; e <= 5; e++) tick();
      checks++;
      if (clk10 !== 1'b1 || rise10 !== 1'b1 || cyc10 !== 32'd1) begin
         errors++;
         $display("FAIL pre_areset: clk/rise=%b%b cycles=%0d, want 11 cycles=1",
                  clk10, rise10, cyc10);
      end
      // Mid-cycle, well away from either clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({clk10, rise10, fall10} !== 3'b000 || cyc10 !== 32'd0) begin
         errors++;
         $display("FAIL areset_immediate: clk/rise/fall=%b%b%b cycles=%0d, want 000 cycles=0",
                  clk10, rise10, fall10, cyc10);
      end
      @(negedge ref_clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         checks++;
         if (clk10 !== (e == 5) || cyc10 !== 32'(e == 5)) begin
            errors++;
            $display("FAIL restart_edge%0d: clk=%b cycles=%0d, want clk=%b cycles=%0d",
                     e, clk10, cyc10, (e == 5), (e == 5));
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0] want [5];
      want = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      // Rises at edges 2, 6, 10, 14, 18.
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (rise4 !== 1'b1 || cyc4 !== want[k]) begin
            errors++;
            $display("FAIL wrap_period%0d: rise=%b cycles=%0d, want rise=1 cycles=%0d",
                     k + 1, rise4, cyc4, want[k]);
         end
         if (k < 4) for (int j = 0; j < 3; j++) tick();
      end
   endtask

   initial begin
      test_reset();
      test_period10();
      test_period3();
      test_period2();
      test_enable_hold();
      test_async_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_gen.md
Name: clk_gen

Overview:
- Synthesizable clock generator. Derives a free-running, glitch-free square-wave `clk` from a reference clock `ref_clk`.
- The output period is exactly CLOCK_PERIOD reference cycles.
- Also provides single-cycle rise/fall strobes and a count of completed output periods.
- Sits at the top of the RISC-V core's clocking tree, driving core logic and benches that need a divided clock.

Parameters:
- CLOCK_PERIOD, 10, output period in ref_clk cycles. Legal range is ≥ 2; any value < 2 must cause an elaboration error.
- CNT_W, 32, width of the `cycles` counter.

Ports:
- ref_clk  input  1  reference clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; when low, all state holds.
- clk  output  1  generated clock, registered (driven directly from a flop).
- rise  output  1  one-ref_clk-cycle pulse, high in the cycle in which `clk` first reads 1.
- fall  output  1  one-ref_clk-cycle pulse, high in the cycle in which `clk` first reads 0 after being high.
- cycles  output  CNT_W  number of `clk` rising edges since reset, modulo 2^CNT_W.

Behaviour:
- Constants:
  - HIGH = floor(CLOCK_PERIOD/2).
  - LOW = CLOCK_PERIOD − HIGH, so LOW ≥ HIGH.
  - Odd periods therefore spend the extra cycle low.
- Internal phase counter `p`, width $clog2(CLOCK_PERIOD), range 0..CLOCK_PERIOD−1.
- Reset (rst_n=0): takes effect immediately and asynchronously, including mid-period or while clk is high.
  - p=0, clk=0, rise=0, fall=0, cycles=0.
  - Held as long as rst_n=0.
- Each ref_clk rising edge with rst_n=1 and en=1:
  - p_next = (p==CLOCK_PERIOD−1) ? 0 : p+1; then p <= p_next.
  - clk <= (p_next ≥ LOW).
  - rise <= (p_next == LOW).
  - fall <= (p_next == 0).
  - cycles <= cycles + 1 when p_next == LOW; wraps silently at 2^CNT_W.
- Each ref_clk rising edge with en=0:
  - p, clk and cycles hold.
  - rise=0 and fall=0.
  - Output frozen at its current level with no glitch.
  - Re-asserting en resumes from the held phase.
- Resulting waveform after reset release with en=1:
  - clk is low for LOW cycles, counting the post-reset cycle with p=0; then high for HIGH cycles; repeating.
  - First rising edge of clk occurs on the LOW-th ref_clk edge.
  - Period is exactly CLOCK_PERIOD ref_clk cycles; duty = HIGH/CLOCK_PERIOD.
- Strobes:
  - rise and fall are never simultaneously high.
  - Each is high for exactly one ref_clk cycle per period while en=1.
- CLOCK_PERIOD=2: clk toggles every ref_clk edge; rise and fall alternate.
- No combinational path from any input to clk. rst_n is the only asynchronous path.

Test Plan:
- CLOCK_PERIOD=10, en=1, release reset:
  - clk=0 through ref edge 4, rises at edge 5, falls at edge 10, rises again at edge 15.
  - rise pulses at edges 5 and 15; fall pulses at edge 10; cycles=1 after edge 5, 2 after edge 15.
- CLOCK_PERIOD=3: clk pattern low, low, high, repeating (LOW=2, HIGH=1); period 3 edges; 100 edges produce cycles=33.
- CLOCK_PERIOD=2: clk toggles each edge; rise and fall alternate each edge; cycles increments every 2 edges.
- en deasserted for 7 edges while clk=1 at p=7 (period 10):
  - clk stays 1; rise and fall stay 0; cycles unchanged.
  - After re-enable, clk falls exactly 3 edges later.
- rst_n pulsed low asynchronously while clk=1 mid-period: clk, rise, fall and cycles go to 0 immediately, without waiting for a ref_clk edge; after release the full low phase of LOW cycles restarts.
- CNT_W=2, CLOCK_PERIOD=4, run 5 output periods: cycles sequence 1, 2, 3, 0, 1 (wrap).
